// File: rtl/geofence_pkg.sv
// Shared state encoding, default sizes and width helper for the N-vertex geofence.
package geofence_pkg;

    localparam int unsigned N_VERT_DEF = 6;
    localparam int unsigned CW_DEF     = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SORT,
        CHECK,
        DONE
    } state_t;

    // Width of a full-precision cross product of two (cw+1)-bit signed vectors.
    function automatic int unsigned cross_w(input int unsigned cw);
        return 2 * cw + 3;
    endfunction

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed 2-D cross product (p1-p0) x (q1-q0) on unsigned coordinates.
module geofence_cross
    import geofence_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic [CW-1:0]                 p0x,
    input  logic [CW-1:0]                 p0y,
    input  logic [CW-1:0]                 p1x,
    input  logic [CW-1:0]                 p1y,
    input  logic [CW-1:0]                 q0x,
    input  logic [CW-1:0]                 q0y,
    input  logic [CW-1:0]                 q1x,
    input  logic [CW-1:0]                 q1y,
    output logic signed [cross_w(CW)-1:0] cross_c
);

    localparam int unsigned DW = CW + 1;
    localparam int unsigned PW = 2 * CW + 2;
    localparam int unsigned XW = cross_w(CW);

    logic signed [DW-1:0] ax;
    logic signed [DW-1:0] ay;
    logic signed [DW-1:0] bx;
    logic signed [DW-1:0] by;
    logic signed [PW-1:0] m0;
    logic signed [PW-1:0] m1;

    always_comb begin
        ax      = $signed({1'b0, p1x}) - $signed({1'b0, p0x});
        ay      = $signed({1'b0, p1y}) - $signed({1'b0, p0y});
        bx      = $signed({1'b0, q1x}) - $signed({1'b0, q0x});
        by      = $signed({1'b0, q1y}) - $signed({1'b0, q0y});
        m0      = PW'(ax) * PW'(by);
        m1      = PW'(ay) * PW'(bx);
        cross_c = XW'(m0) - XW'(m1);
    end

endmodule

// File: rtl/geofence_n.sv
// Point-in-convex-polygon test: load target and N_VERT vertices, angle-sort, check edges.
// Optional on_edge result and zero-flag logic are built when GEOFENCE_EDGE_EN is defined.
module geofence_n
    import geofence_pkg::*;
#(
    parameter int unsigned N_VERT = N_VERT_DEF,
    parameter int unsigned CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          busy,
    output logic          valid,
    output logic          is_inside
`ifdef GEOFENCE_EDGE_EN
  , output logic          on_edge
`endif
);

    localparam int unsigned IW = $clog2(N_VERT);
    localparam int unsigned XW = cross_w(CW);
    localparam logic signed [XW-1:0] ZERO = '0;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic [IW-1:0]     idx_wrap;
    logic              swapped;
    logic              swapped_nxt;
    logic              idx_last;
    logic              sort_last;

    logic [CW-1:0]     tx;
    logic [CW-1:0]     ty;
    logic [CW-1:0]     vx [N_VERT];
    logic [CW-1:0]     vy [N_VERT];

    logic [CW-1:0]     p0x;
    logic [CW-1:0]     p0y;
    logic [CW-1:0]     q0x;
    logic [CW-1:0]     q0y;
    logic signed [XW-1:0] cross_c;
    logic              cneg;

    logic [N_VERT-1:0] neg_flags;
    logic [N_VERT-1:0] neg_vec_c;
    logic              inside_c;
    logic              busy_d;
    logic              valid_d;
    logic              inside_d;
`ifdef GEOFENCE_EDGE_EN
    logic [N_VERT-1:0] zero_flags;
    logic [N_VERT-1:0] zero_vec_c;
    logic [N_VERT-1:0] pos_vec_c;
    logic              edge_c;
    logic              edge_d;
`endif

    assign idx_last  = (idx == IW'(N_VERT - 1));
    assign sort_last = (idx == IW'(N_VERT - 2));
    assign idx_wrap  = idx_last ? '0 : idx + IW'(1);

    // SORT compares (v[i]-v0)x(v[i+1]-v0); CHECK evaluates (v[k]-t)x(v[k+1]-v[k]).
    always_comb begin
        p0x = tx;
        p0y = ty;
        q0x = vx[idx];
        q0y = vy[idx];
        if (state == SORT) begin
            p0x = vx[0];
            p0y = vy[0];
            q0x = vx[0];
            q0y = vy[0];
        end
    end

    geofence_cross #(.CW(CW)) u_cross (
        .p0x     (p0x),
        .p0y     (p0y),
        .p1x     (vx[idx]),
        .p1y     (vy[idx]),
        .q0x     (q0x),
        .q0y     (q0y),
        .q1x     (vx[idx_wrap]),
        .q1y     (vy[idx_wrap]),
        .cross_c (cross_c)
    );

    assign cneg = (cross_c < ZERO);

    // Edge flags including the edge being evaluated this cycle.
    always_comb begin
        neg_vec_c      = neg_flags;
        neg_vec_c[idx] = cneg;
`ifdef GEOFENCE_EDGE_EN
        zero_vec_c      = zero_flags;
        zero_vec_c[idx] = (cross_c == ZERO);
        pos_vec_c       = ~neg_vec_c & ~zero_vec_c;
        edge_c          = (|zero_vec_c) & ~((|neg_vec_c) & (|pos_vec_c));
        inside_c        = ((&neg_vec_c) | ~(|neg_vec_c)) & ~edge_c;
`else
        inside_c        = (&neg_vec_c) | ~(|neg_vec_c);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            swapped   <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            is_inside <= 1'b0;
`ifdef GEOFENCE_EDGE_EN
            on_edge   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            swapped   <= swapped_nxt;
            busy      <= busy_d;
            valid     <= valid_d;
            is_inside <= inside_d;
`ifdef GEOFENCE_EDGE_EN
            on_edge   <= edge_d;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        swapped_nxt = swapped;
        case (state)
            IDLE: if (in_valid) begin
                state_nxt = LOAD;
                idx_nxt   = '0;
            end
            LOAD: if (in_valid) begin
                if (idx_last) begin
                    state_nxt   = SORT;
                    idx_nxt     = IW'(1);
                    swapped_nxt = 1'b0;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            SORT: if (sort_last) begin
                if (swapped || !cneg) begin
                    idx_nxt     = IW'(1);
                    swapped_nxt = 1'b0;
                end else begin
                    state_nxt = CHECK;
                    idx_nxt   = '0;
                end
            end else begin
                idx_nxt     = idx + IW'(1);
                swapped_nxt = swapped | ~cneg;
            end
            CHECK: if (idx_last) begin
                state_nxt = DONE;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx_wrap;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_d   = busy;
        valid_d  = 1'b0;
        inside_d = is_inside;
`ifdef GEOFENCE_EDGE_EN
        edge_d   = on_edge;
`endif
        case (state)
            IDLE: if (in_valid) busy_d = 1'b1;
            CHECK: if (idx_last) begin
                valid_d  = 1'b1;
                inside_d = inside_c;
`ifdef GEOFENCE_EDGE_EN
                edge_d   = edge_c;
`endif
            end
            DONE:    busy_d = 1'b0;
            default: ;
        endcase
    end

    // Coordinate and flag storage; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            tx <= X;
            ty <= Y;
        end
        if (state == LOAD && in_valid) begin
            vx[idx] <= X;
            vy[idx] <= Y;
        end
        if (state == SORT && !cneg) begin
            vx[idx]      <= vx[idx_wrap];
            vy[idx]      <= vy[idx_wrap];
            vx[idx_wrap] <= vx[idx];
            vy[idx_wrap] <= vy[idx];
        end
        if (state == CHECK) begin
            neg_flags  <= neg_vec_c;
`ifdef GEOFENCE_EDGE_EN
            zero_flags <= zero_vec_c;
`endif
        end
    end

endmodule

// File: tb/tb_geofence_n.sv
// Directed bench for geofence_n: square (N_VERT=4) and hexagon (N_VERT=6) instances.
module tb_geofence_n;

    localparam int unsigned CW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          iv4 = 1'b0;
    logic [CW-1:0] X4 = '0;
    logic [CW-1:0] Y4 = '0;
    logic          busy4, valid4, ins4;
    logic          iv6 = 1'b0;
    logic [CW-1:0] X6 = '0;
    logic [CW-1:0] Y6 = '0;
    logic          busy6, valid6, ins6;
`ifdef GEOFENCE_EDGE_EN
    logic          edge4, edge6;
    logic          edge_seen;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int sq_x [4] = '{0, 10, 10, 0};
    int sq_y [4] = '{0, 0, 10, 10};
    int ro_x [4] = '{0, 10, 0, 10};
    int ro_y [4] = '{0, 10, 10, 0};
    int hx   [6] = '{512, 900, 900, 512, 124, 124};
    int hy   [6] = '{100, 300, 700, 900, 700, 300};

    always #5 clk = ~clk;

    geofence_n #(.N_VERT(4), .CW(CW)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .X(X4), .Y(Y4),
        .busy(busy4), .valid(valid4), .is_inside(ins4)
`ifdef GEOFENCE_EDGE_EN
      , .on_edge(edge4)
`endif
    );

    geofence_n #(.N_VERT(6), .CW(CW)) dut6 (
        .clk(clk), .reset(reset), .in_valid(iv6), .X(X6), .Y(Y6),
        .busy(busy6), .valid(valid6), .is_inside(ins6)
`ifdef GEOFENCE_EDGE_EN
      , .on_edge(edge6)
`endif
    );

    // One N_VERT=4 transaction; latency counted in cycles from the last vertex accepted.
    task automatic run4(input int tx, input int ty, input int px [4], input int py [4],
                        input int gap_at, input bit junk, output int lat, output logic ins,
                        output logic busy_mid, output logic valid_after, output logic busy_after);
        @(negedge clk);
        iv4 = 1'b1; X4 = CW'(tx); Y4 = CW'(ty);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == gap_at) begin
                iv4 = 1'b0;
                repeat (3) @(negedge clk);
            end
            iv4 = 1'b1; X4 = CW'(px[i]); Y4 = CW'(py[i]);
        end
        @(negedge clk);
        iv4 = junk; X4 = CW'($urandom); Y4 = CW'($urandom);
        busy_mid = busy4;
        lat = 1;
        while (valid4 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (junk) begin X4 = CW'($urandom); Y4 = CW'($urandom); end
        end
        ins = ins4;
`ifdef GEOFENCE_EDGE_EN
        edge_seen = edge4;
`endif
        @(negedge clk);
        iv4 = 1'b0;
        valid_after = valid4;
        busy_after  = busy4;
    endtask

    task automatic run6(input int tx, input int ty, output int lat, output logic ins);
        @(negedge clk);
        iv6 = 1'b1; X6 = CW'(tx); Y6 = CW'(ty);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            X6 = CW'(hx[i]); Y6 = CW'(hy[i]);
        end
        @(negedge clk);
        iv6 = 1'b0;
        lat = 1;
        while (valid6 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        ins = ins6;
`ifdef GEOFENCE_EDGE_EN
        edge_seen = edge6;
`endif
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
        n_checks++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid4: got %b expected 0", valid4); end
        n_checks++; if (ins4 !== 1'b0) begin n_fail++; $display("FAIL reset_inside4: got %b expected 0", ins4); end
        n_checks++; if (busy6 !== 1'b0) begin n_fail++; $display("FAIL reset_busy6: got %b expected 0", busy6); end
        n_checks++; if (valid6 !== 1'b0) begin n_fail++; $display("FAIL reset_valid6: got %b expected 0", valid6); end
`ifdef GEOFENCE_EDGE_EN
        n_checks++; if (edge4 !== 1'b0) begin n_fail++; $display("FAIL reset_edge4: got %b expected 0", edge4); end
`endif
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_square;
        int lat; logic ins, bm, va, ba;
        run4(5, 5, sq_x, sq_y, -1, 1'b0, lat, ins, bm, va, ba);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL square_latency: got %0d expected 11", lat); end
        n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL square_inside: got %b expected 1", ins); end
        n_checks++; if (bm !== 1'b1) begin n_fail++; $display("FAIL square_busy_mid: got %b expected 1", bm); end
        n_checks++; if (va !== 1'b0) begin n_fail++; $display("FAIL square_valid_one_cycle: got %b expected 0", va); end
        n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL square_busy_after: got %b expected 0", ba); end
`ifdef GEOFENCE_EDGE_EN
        n_checks++; if (edge_seen !== 1'b0) begin n_fail++; $display("FAIL square_on_edge: got %b expected 0", edge_seen); end
`endif
    endtask

    task automatic test_outside;
        int lat; logic ins, bm, va, ba;
        run4(20, 5, sq_x, sq_y, -1, 1'b0, lat, ins, bm, va, ba);
        n_checks++; if (ins !== 1'b0) begin n_fail++; $display("FAIL outside_inside: got %b expected 0", ins); end
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL outside_latency: got %0d expected 11", lat); end
    endtask

    task automatic test_edge;
        int lat; logic ins, bm, va, ba;
        run4(10, 5, sq_x, sq_y, -1, 1'b0, lat, ins, bm, va, ba);
        n_checks++; if (ins !== 1'b0) begin n_fail++; $display("FAIL edge_inside: got %b expected 0", ins); end
`ifdef GEOFENCE_EDGE_EN
        n_checks++; if (edge_seen !== 1'b1) begin n_fail++; $display("FAIL edge_on_edge: got %b expected 1", edge_seen); end
`endif
    endtask

    task automatic test_reorder_stall;
        int lat; logic ins, bm, va, ba;
        run4(5, 5, ro_x, ro_y, 2, 1'b0, lat, ins, bm, va, ba);
        n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL reorder_inside: got %b expected 1", ins); end
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL reorder_latency: got %0d expected 9", lat); end
    endtask

    task automatic test_hexagon;
        int lat; logic ins;
        run6(1023, 1023, lat, ins);
        n_checks++; if (ins !== 1'b0) begin n_fail++; $display("FAIL hex_far_inside: got %b expected 0", ins); end
        n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL hex_far_latency: got %0d expected 27", lat); end
        run6(512, 500, lat, ins);
        n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL hex_center_inside: got %b expected 1", ins); end
        n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL hex_center_latency: got %0d expected 27", lat); end
    endtask

    task automatic test_reset_mid_sort;
        int lat; logic ins, bm, va, ba;
        bit seen;
        @(negedge clk);
        iv4 = 1'b1; X4 = CW'(5); Y4 = CW'(5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            X4 = CW'(sq_x[i]); Y4 = CW'(sq_y[i]);
        end
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL midsort_busy: got %b expected 0", busy4); end
        n_checks++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL midsort_valid: got %b expected 0", valid4); end
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid4 !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midsort_no_pulse: got %b expected 0", seen); end
        run4(5, 5, sq_x, sq_y, -1, 1'b0, lat, ins, bm, va, ba);
        n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL midsort_next_inside: got %b expected 1", ins); end
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL midsort_next_latency: got %0d expected 11", lat); end
    endtask

    // in_valid held high with junk through SORT/CHECK/DONE, then transactions back to back.
    task automatic test_back_to_back;
        int lat; logic ins, bm, va, ba;
        run4(5, 5, sq_x, sq_y, -1, 1'b1, lat, ins, bm, va, ba);
        n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL b2b_junk_inside: got %b expected 1", ins); end
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL b2b_junk_latency: got %0d expected 11", lat); end
        n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ignored: busy got %b expected 0", ba); end
        run4(20, 5, ro_x, ro_y, -1, 1'b0, lat, ins, bm, va, ba);
        n_checks++; if (ins !== 1'b0) begin n_fail++; $display("FAIL b2b_second_inside: got %b expected 0", ins); end
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 9", lat); end
        run4(5, 5, ro_x, ro_y, -1, 1'b0, lat, ins, bm, va, ba);
        n_checks++; if (ins !== 1'b1) begin n_fail++; $display("FAIL b2b_third_inside: got %b expected 1", ins); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_outside();
        test_edge();
        test_reorder_stall();
        test_hexagon();
        test_reset_mid_sort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
